// File: rtl/qslave_seq_if.sv
// QBUS slave sequencer bus bundle: received control/data lines toward the
// sequencer and transceiver/device controls back out.
interface qslave_seq_if;
  logic        RSYNC;
  logic        RDIN;
  logic        RDOUT;
  logic        RINIT;
  logic        addr_match;
  logic        vector_req;
  logic [15:0] RDL;
  logic [15:0] rd_data;
  logic [15:0] TDL;
  logic        DALtx;
  logic        DALst;
  logic        DALbe;
  logic        TRPLY;
  logic [15:0] wr_data;
  logic        wr_strobe;
  logic        rd_strobe;
  logic        busy;

  modport master (
    output RSYNC, RDIN, RDOUT, RINIT, addr_match, vector_req, RDL, rd_data,
    input  TDL, DALtx, DALst, DALbe, TRPLY, wr_data, wr_strobe, rd_strobe, busy
  );

  modport slave (
    input  RSYNC, RDIN, RDOUT, RINIT, addr_match, vector_req, RDL, rd_data,
    output TDL, DALtx, DALst, DALbe, TRPLY, wr_data, wr_strobe, rd_strobe, busy
  );
endinterface

// File: rtl/qslave_seq.sv
// QBUS slave reply sequencer: synchronizes the received bus handshake and
// steps DATI/DATO/DATIO/IAK cycles through registered transceiver controls.
module qslave_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk20,
  input  logic         reset,
  qslave_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SETUP = 3'd1,
    RD_REPLY = 3'd2,
    WR_REPLY = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [5:0]  meta_r;
  logic [5:0]  sync_r;
  logic        sRSYNC, sRDIN, sRDOUT, sRINIT, saddr_match, svector_req;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        vec_r, vec_s;
  logic        wr_done_r, wr_done_s;
  logic [15:0] tdl_r, tdl_s;
  logic [15:0] wr_data_r, wr_data_s;
  logic        daltx_r, daltx_s;
  logic        dalst_r, dalst_s;
  logic        dalbe_r, dalbe_s;
  logic        trply_r, trply_s;
  logic        rd_strobe_r, rd_strobe_s;
  logic        wr_strobe_r, wr_strobe_s;
  logic        busy_r, busy_s;
  logic        read_req_s, write_req_s, abort_s;

  assign {sRSYNC, sRDIN, sRDOUT, sRINIT, saddr_match, svector_req} = sync_r;

  // Two-flop synchronizer for all asynchronous bus and decode inputs
  always_ff @(posedge clk20) begin
    if (reset) begin
      meta_r <= 6'b000000;
      sync_r <= 6'b000000;
    end else begin
      meta_r <= {bus.RSYNC, bus.RDIN, bus.RDOUT, bus.RINIT, bus.addr_match, bus.vector_req};
      sync_r <= meta_r;
    end
  end

  // A vector read (IAK) arrives with SYNC low; only a data cycle can be aborted by SYNC dropping
  assign read_req_s  = sRDIN & ((sRSYNC & saddr_match) | (~sRSYNC & svector_req));
  assign write_req_s = sRDOUT & sRSYNC & saddr_match & ~sRDIN;
  assign abort_s     = ~sRSYNC & ~vec_r;

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    vec_s       = vec_r;
    wr_done_s   = wr_done_r;
    tdl_s       = tdl_r;
    wr_data_s   = wr_data_r;
    daltx_s     = 1'b0;
    dalst_s     = 1'b0;
    dalbe_s     = 1'b0;
    trply_s     = 1'b0;
    rd_strobe_s = 1'b0;
    wr_strobe_s = 1'b0;
    if (sRINIT) begin
      state_s   = IDLE;
      cnt_s     = 4'd0;
      vec_s     = 1'b0;
      wr_done_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_done_s = 1'b0;
          if (read_req_s) begin
            state_s = RD_SETUP;
            vec_s   = ~sRSYNC;
            cnt_s   = 4'd1;
            daltx_s = 1'b1;
            tdl_s   = bus.rd_data;
          end else if (write_req_s) begin
            state_s     = WR_REPLY;
            vec_s       = 1'b0;
            wr_done_s   = 1'b1;
            wr_data_s   = bus.RDL;
            wr_strobe_s = 1'b1;
            trply_s     = 1'b1;
          end else begin
            vec_s = 1'b0;
          end
        end
        RD_SETUP: begin
          if (abort_s) begin
            state_s = IDLE;
          end else if (cnt_r == SETTLE_C) begin
            state_s = RD_REPLY;
            tdl_s   = bus.rd_data;
            daltx_s = 1'b1;
            dalbe_s = 1'b1;
            trply_s = 1'b1;
            dalst_s = 1'b1;
          end else begin
            cnt_s   = cnt_r + 4'd1;
            tdl_s   = bus.rd_data;
            daltx_s = 1'b1;
          end
        end
        RD_REPLY: begin
          if (abort_s) begin
            state_s = IDLE;
          end else if (!sRDIN) begin
            rd_strobe_s = 1'b1;
            state_s     = vec_r ? IDLE : HOLD;
          end else begin
            daltx_s = 1'b1;
            dalbe_s = 1'b1;
            trply_s = 1'b1;
          end
        end
        WR_REPLY: begin
          if (abort_s) begin
            state_s = IDLE;
          end else if (!sRDOUT) begin
            state_s = HOLD;
          end else begin
            trply_s = 1'b1;
          end
        end
        HOLD: begin
          // Further RDIN within this SYNC is ignored; only one write half is accepted
          if (!sRSYNC) begin
            state_s = IDLE;
          end else if (sRDOUT && saddr_match && !wr_done_r) begin
            state_s     = WR_REPLY;
            wr_done_s   = 1'b1;
            wr_data_s   = bus.RDL;
            wr_strobe_s = 1'b1;
            trply_s     = 1'b1;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State and registered output update
  always_ff @(posedge clk20) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      vec_r       <= 1'b0;
      wr_done_r   <= 1'b0;
      tdl_r       <= 16'h0000;
      wr_data_r   <= 16'h0000;
      daltx_r     <= 1'b0;
      dalst_r     <= 1'b0;
      dalbe_r     <= 1'b0;
      trply_r     <= 1'b0;
      rd_strobe_r <= 1'b0;
      wr_strobe_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      vec_r       <= vec_s;
      wr_done_r   <= wr_done_s;
      tdl_r       <= tdl_s;
      wr_data_r   <= wr_data_s;
      daltx_r     <= daltx_s;
      dalst_r     <= dalst_s;
      dalbe_r     <= dalbe_s;
      trply_r     <= trply_s;
      rd_strobe_r <= rd_strobe_s;
      wr_strobe_r <= wr_strobe_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.TDL       = tdl_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.DALtx     = daltx_r;
  assign bus.DALst     = dalst_r;
  assign bus.DALbe     = dalbe_r;
  assign bus.TRPLY     = trply_r;
  assign bus.rd_strobe = rd_strobe_r;
  assign bus.wr_strobe = wr_strobe_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_qslave_seq.sv
// Bench for qslave_seq: directed and randomized QBUS cycles checked against
// transaction-level expectations (who replies, how many strobes, data values).
module tb_qslave_seq;
  localparam int unsigned SETTLE = 4;
  localparam int K_DATI  = 0;
  localparam int K_DATO  = 1;
  localparam int K_DATIO = 2;
  localparam int K_IAK   = 3;

  logic clk20 = 1'b0;
  logic reset = 1'b1;

  qslave_seq_if bus();

  qslave_seq #(.SETTLE(SETTLE)) dut (
    .clk20 (clk20),
    .reset (reset),
    .bus   (bus)
  );

  always #25 clk20 = ~clk20;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_cnt = 0, wr_cnt = 0, both_cnt = 0, trply_rise = 0;
  logic trply_prev = 1'b0;

  // Event monitor: strobe and reply-pulse tallies
  always @(negedge clk20) begin
    if (bus.rd_strobe === 1'b1) rd_cnt++;
    if (bus.wr_strobe === 1'b1) wr_cnt++;
    if (bus.rd_strobe === 1'b1 && bus.wr_strobe === 1'b1) both_cnt++;
    if (bus.TRPLY === 1'b1 && trply_prev !== 1'b1) trply_rise++;
    trply_prev = bus.TRPLY;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk20);
    #1;
  endtask

  task automatic idle_bus();
    bus.RSYNC = 1'b0; bus.RDIN = 1'b0; bus.RDOUT = 1'b0; bus.RINIT = 1'b0;
    bus.addr_match = 1'b0; bus.vector_req = 1'b0;
    bus.RDL = 16'h0000; bus.rd_data = 16'h0000;
  endtask

  task automatic wait_trply(input logic val, input int maxc, output logic ok, output int dtx);
    ok = 1'b0; dtx = 0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (bus.TRPLY === val) begin ok = 1'b1; break; end
      if (bus.DALtx === 1'b1) dtx++;
    end
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b1;
    tick(3);
    n_tests++;
    if ({bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.wr_strobe, bus.busy} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.wr_strobe, bus.busy});
    end
    n_tests++;
    if (bus.TDL !== 16'h0000) begin n_fail++; $display("FAIL reset_tdl: got %h expected 0000", bus.TDL); end
    n_tests++;
    if (bus.wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wrdata: got %h expected 0000", bus.wr_data); end
    reset = 1'b0;
    tick(2);
  endtask

  // One complete bus cycle; expectations derive from who should answer it
  task automatic do_transfer(input int kind, input logic match, input logic vreq,
                             input logic [15:0] rdv, input logic [15:0] wdv);
    logic ok; int dtx;
    int rd0, wr0, b0, t0, exp_rd, exp_wr;
    bit is_rd, is_wr, rd_reply;
    is_rd = (kind != K_DATO);
    is_wr = (kind == K_DATO) || (kind == K_DATIO);
    rd_reply = (kind == K_IAK) ? vreq : match;
    exp_rd = (is_rd && rd_reply) ? 1 : 0;
    exp_wr = (is_wr && match) ? 1 : 0;
    rd0 = rd_cnt; wr0 = wr_cnt; b0 = both_cnt; t0 = trply_rise;
    bus.addr_match = match; bus.vector_req = vreq; bus.rd_data = rdv; bus.RDL = wdv;
    if (kind != K_IAK) begin bus.RSYNC = 1'b1; tick(2); end
    if (is_rd) begin
      bus.RDIN = 1'b1;
      wait_trply(1'b1, SETTLE + 8, ok, dtx);
      if (rd_reply) begin
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_reply_timeout: kind %0d got no TRPLY expected TRPLY", kind); end
        n_tests++;
        if (dtx != SETTLE) begin n_fail++; $display("FAIL rd_settle: got %0d expected %0d", dtx, SETTLE); end
        n_tests++;
        if (bus.TDL !== rdv) begin n_fail++; $display("FAIL rd_tdl: got %o expected %o", bus.TDL, rdv); end
        n_tests++;
        if (bus.DALst !== 1'b1) begin n_fail++; $display("FAIL dalst_first: got %b expected 1", bus.DALst); end
        tick(1);
        n_tests++;
        if ({bus.DALst, bus.TRPLY, bus.DALtx, bus.DALbe} !== 4'b0111) begin
          n_fail++; $display("FAIL reply_hold: got %b expected 0111", {bus.DALst, bus.TRPLY, bus.DALtx, bus.DALbe});
        end
        bus.RDIN = 1'b0;
        wait_trply(1'b0, 8, ok, dtx);
        n_tests++;
        if (ok !== 1'b1 || bus.DALtx !== 1'b0) begin n_fail++; $display("FAIL rd_release: got ok=%b DALtx=%b expected 1 0", ok, bus.DALtx); end
        n_tests++;
        if (bus.busy !== (kind != K_IAK)) begin n_fail++; $display("FAIL busy_after_read: kind %0d got %b expected %b", kind, bus.busy, kind != K_IAK); end
      end else begin
        n_tests++;
        if (ok !== 1'b0 || dtx != 0) begin n_fail++; $display("FAIL rd_noreply: got TRPLY=%b DALtx cycles=%0d expected 0 0", ok, dtx); end
        bus.RDIN = 1'b0;
        tick(3);
      end
    end
    if (is_wr) begin
      bus.RDOUT = 1'b1;
      wait_trply(1'b1, 8, ok, dtx);
      if (match) begin
        n_tests++;
        if (ok !== 1'b1 || bus.wr_data !== wdv) begin n_fail++; $display("FAIL wr_reply: got ok=%b wr_data=%o expected 1 %o", ok, bus.wr_data, wdv); end
        tick(5);
        n_tests++;
        if (bus.TRPLY !== 1'b1) begin n_fail++; $display("FAIL wr_trply_held: got %b expected 1", bus.TRPLY); end
        bus.RDOUT = 1'b0;
        wait_trply(1'b0, 8, ok, dtx);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_release: got TRPLY stuck expected 0"); end
      end else begin
        n_tests++;
        if (ok !== 1'b0) begin n_fail++; $display("FAIL wr_noreply: got TRPLY=1 expected 0"); end
        bus.RDOUT = 1'b0;
        tick(3);
      end
    end
    bus.RSYNC = 1'b0;
    tick(4);
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL end_idle: got busy=%b expected 0", bus.busy); end
    n_tests++;
    if (rd_cnt - rd0 != exp_rd || wr_cnt - wr0 != exp_wr || both_cnt != b0) begin
      n_fail++; $display("FAIL strobes: kind %0d got rd=%0d wr=%0d both=%0d expected rd=%0d wr=%0d both=0",
        kind, rd_cnt - rd0, wr_cnt - wr0, both_cnt - b0, exp_rd, exp_wr);
    end
    n_tests++;
    if (trply_rise - t0 != exp_rd + exp_wr) begin
      n_fail++; $display("FAIL trply_pulses: kind %0d got %0d expected %0d", kind, trply_rise - t0, exp_rd + exp_wr);
    end
    idle_bus();
    tick(2);
  endtask

  task automatic test_directed();
    do_transfer(K_DATI,  1'b1, 1'b0, 16'o123456, 16'o000000);
    do_transfer(K_DATO,  1'b1, 1'b0, 16'o000000, 16'o000377);
    do_transfer(K_DATIO, 1'b1, 1'b0, 16'o052525, 16'o125252);
    do_transfer(K_IAK,   1'b0, 1'b1, 16'o000220, 16'o000000);
    do_transfer(K_DATI,  1'b0, 1'b0, 16'o177777, 16'o000000);
    do_transfer(K_DATO,  1'b0, 1'b0, 16'o000000, 16'o177777);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_transfer($urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_hold_ignore();
    logic ok; int dtx; int rd0;
    rd0 = rd_cnt;
    bus.addr_match = 1'b1; bus.rd_data = 16'o007070; bus.RSYNC = 1'b1;
    tick(2);
    bus.RDIN = 1'b1;
    wait_trply(1'b1, SETTLE + 8, ok, dtx);
    bus.RDIN = 1'b0;
    wait_trply(1'b0, 8, ok, dtx);
    tick(2);
    bus.RDIN = 1'b1;
    wait_trply(1'b1, SETTLE + 8, ok, dtx);
    n_tests++;
    if (ok !== 1'b0 || dtx != 0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_ignore: got TRPLY=%b DALtx=%0d busy=%b expected 0 0 1", ok, dtx, bus.busy);
    end
    bus.RDIN = 1'b0; bus.RSYNC = 1'b0;
    tick(4);
    n_tests++;
    if (rd_cnt - rd0 != 1) begin n_fail++; $display("FAIL hold_rd_count: got %0d expected 1", rd_cnt - rd0); end
    idle_bus();
    tick(2);
  endtask

  task automatic test_abort();
    logic ok; int rd0, t0;
    rd0 = rd_cnt; t0 = trply_rise;
    bus.addr_match = 1'b1; bus.rd_data = 16'o111111; bus.RSYNC = 1'b1;
    tick(2);
    bus.RDIN = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.DALtx === 1'b1) begin ok = 1'b1; break; end
    end
    bus.RSYNC = 1'b0;
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_setup: got no DALtx expected DALtx"); end
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (ok !== 1'b1 || {bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.wr_strobe} !== 6'b0) begin
      n_fail++; $display("FAIL abort_outputs: got idle=%b ctrl=%b expected 1 000000", ok,
        {bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.wr_strobe});
    end
    bus.RDIN = 1'b0;
    tick(4);
    n_tests++;
    if (rd_cnt != rd0 || trply_rise != t0) begin
      n_fail++; $display("FAIL abort_strobe: got rd=%0d trply=%0d expected 0 0", rd_cnt - rd0, trply_rise - t0);
    end
    idle_bus();
    tick(2);
  endtask

  task automatic test_rinit();
    logic ok; int dtx; int wr0;
    wr0 = wr_cnt;
    bus.addr_match = 1'b1; bus.RDL = 16'o000077; bus.RSYNC = 1'b1;
    tick(2);
    bus.RDOUT = 1'b1;
    wait_trply(1'b1, 8, ok, dtx);
    bus.RINIT = 1'b1;
    wait_trply(1'b0, 6, ok, dtx);
    n_tests++;
    if (ok !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rinit_force: got ok=%b busy=%b expected 1 0", ok, bus.busy); end
    tick(4);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.TRPLY !== 1'b0) begin n_fail++; $display("FAIL rinit_hold: got busy=%b TRPLY=%b expected 0 0", bus.busy, bus.TRPLY); end
    bus.RDOUT = 1'b0; bus.RSYNC = 1'b0;
    tick(3);
    bus.RINIT = 1'b0;
    tick(4);
    n_tests++;
    if (wr_cnt - wr0 != 1) begin n_fail++; $display("FAIL rinit_wr_count: got %0d expected 1", wr_cnt - wr0); end
    idle_bus();
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic ok; int dtx; int rd0;
    rd0 = rd_cnt;
    bus.addr_match = 1'b1; bus.rd_data = 16'o054321; bus.RSYNC = 1'b1;
    tick(2);
    bus.RDIN = 1'b1;
    wait_trply(1'b1, SETTLE + 8, ok, dtx);
    reset = 1'b1;
    tick(1);
    n_tests++;
    if ({bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.busy} !== 6'b0 || bus.TDL !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid: got ctrl=%b TDL=%o expected 000000 0",
        {bus.TRPLY, bus.DALtx, bus.DALst, bus.DALbe, bus.rd_strobe, bus.busy}, bus.TDL);
    end
    idle_bus();
    tick(3);
    reset = 1'b0;
    tick(3);
    n_tests++;
    if (rd_cnt != rd0) begin n_fail++; $display("FAIL reset_mid_strobe: got %0d expected 0", rd_cnt - rd0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_ignore();
    test_abort();
    test_rinit();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qslave_seq.md
QSLAVE_SEQ -- requirements
Module: qslave_seq

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of clk20 cycles DALtx is held before the reply on a read (legal range 1-15).
REQ-002 The block SHALL have port clk20, input, 1, the 20 MHz QBUS clock; the only clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports RSYNC, RDIN, RDOUT and RINIT, input, 1 each, asynchronous received QBUS control lines.
REQ-005 The block SHALL have port addr_match, input, 1, asynchronous "latched address is mine" from device decode.
REQ-006 The block SHALL have port vector_req, input, 1, asynchronous "device owns the current IAK".
REQ-007 The block SHALL have port RDL, input, 16, received data lines.
REQ-008 The block SHALL have port rd_data, input, 16, register or vector value from the device.
REQ-009 The block SHALL have port TDL, output, 16, data to the Am2908 transmit side.
REQ-010 The block SHALL have ports DALtx, DALst, DALbe and TRPLY, output, 1 each, transceiver direction, transceiver latch, bus enable and reply.
REQ-011 The block SHALL have port wr_data, output, 16, captured write data.
REQ-012 The block SHALL have ports wr_strobe and rd_strobe, output, 1 each, one-cycle device pulses.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 Each asynchronous input SHALL pass a 2-flop synchronizer; the s-prefixed name denotes the second flop.
REQ-015 All outputs SHALL be registered; the state is one of IDLE, RD_SETUP, RD_REPLY, WR_REPLY or HOLD.
REQ-016 From IDLE, the state SHALL move to RD_SETUP when sRDIN & ((sRSYNC & saddr_match) | (~sRSYNC & svector_req)), recording flag vec = ~sRSYNC.
REQ-017 From IDLE, the state SHALL move to WR_REPLY when sRDOUT & sRSYNC & saddr_match & ~sRDIN; if sRDIN and sRDOUT are both high, the read SHALL take priority.
REQ-018 In RD_SETUP, DALtx SHALL be 1 and TDL SHALL load rd_data every cycle; after exactly SETTLE cycles the state SHALL move to RD_REPLY.
REQ-019 In RD_REPLY, DALtx, DALbe and TRPLY SHALL be 1 and TDL SHALL hold its value; DALst SHALL be 1 on the first RD_REPLY cycle only.
REQ-020 On the first cycle sRDIN=0 in RD_REPLY, TRPLY, DALbe and DALtx SHALL go 0, rd_strobe SHALL pulse, and the state SHALL move to IDLE if vec=1, else to HOLD.
REQ-021 On WR_REPLY entry, wr_data SHALL load RDL and wr_strobe SHALL pulse for exactly 1 cycle; TRPLY SHALL be 1 until the first cycle sRDOUT=0, then go 0 with the state moving to HOLD.
REQ-022 In HOLD, a new sRDOUT & saddr_match (DATIO write half) SHALL enter WR_REPLY; sRSYNC=0 SHALL enter IDLE.
REQ-023 A second sRDIN within the same SYNC while in HOLD SHALL be ignored.
REQ-024 sRSYNC falling in RD_SETUP, RD_REPLY or WR_REPLY when vec=0 SHALL abort to IDLE next cycle, with all control outputs 0 and no strobe.
REQ-025 sRINIT=1 SHALL force IDLE and all control outputs to 0 on the next edge, in any state, and the state SHALL stay in IDLE while sRINIT=1.
REQ-026 rd_strobe and wr_strobe SHALL never be high in the same cycle, and each SHALL fire at most once per bus cycle.

Reset
REQ-027 On a clk20 edge with reset=1, the state SHALL be IDLE, all synchronizer flops 0, TRPLY/DALtx/DALst/DALbe/rd_strobe/wr_strobe/busy 0, TDL 0 and wr_data 0.
REQ-028 Reset asserted mid-transfer SHALL take effect on that edge, with no strobe emitted.

Verification
REQ-029 DATI: addr_match=1, rd_data=16'o123456, RSYNC then RDIN -> DALtx 2 cycles, then TRPLY=1 and DALst for 1 cycle, TDL=16'o123456; RDIN drop -> TRPLY 0 and one rd_strobe.
REQ-030 DATO: RDL=16'o000377, RDOUT -> wr_data=16'o000377, exactly one wr_strobe, TRPLY held until RDOUT drops.
REQ-031 DATIO: RDIN cycle then RDOUT in the same SYNC -> rd_strobe followed by wr_strobe, two TRPLY pulses, return to IDLE when RSYNC drops.
REQ-032 IAK: RSYNC=0, vector_req=1, rd_data=16'o000220, RDIN -> TDL=16'o000220 with TRPLY, then IDLE (not HOLD) after RDIN drops.
REQ-033 Abort: RSYNC drops during RD_SETUP -> all outputs 0 next cycle, no rd_strobe; the same cycle with RINIT=1 in WR_REPLY -> TRPLY 0, busy 0.
REQ-034 Non-match: addr_match=0 with RDIN and RDOUT -> TRPLY and DALtx stay 0 and no strobes.
